// File: rtl/gol_pkg.sv
// Shared definitions for the Game of Life board engine.
// Holds the board geometry, game-state and engine-state encodings, and the
// debug view of the engine exported by gol_board_engine.
package gol_pkg;

    localparam int ROWS  = 8;
    localparam int COLS  = 16;
    localparam int CELLS = ROWS * COLS;

    localparam int ROW_W = 3;
    localparam int COL_W = 4;
    localparam int IDX_W = ROW_W + COL_W;

    // Encoding driven by the upstream game-state FSM
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PROGRAM = 2'b01,
        RUN     = 2'b10,
        PAUSE   = 2'b11
    } game_state_e;

    // Generation engine states
    typedef enum logic [1:0] {
        E_IDLE   = 2'b00,
        E_SCAN   = 2'b01,
        E_COMMIT = 2'b10
    } engine_state_e;

    // Observation port: engine state, scan pointer and the neighbour count
    // of the cell currently being evaluated
    typedef struct packed {
        engine_state_e     state;
        logic [IDX_W-1:0]  idx;
        logic [3:0]        nbr_count;
    } engine_dbg_t;

endpackage

// File: rtl/gol_cell_rule.sv
// Combinational Life rule for a single cell of the 8x16 board.
// Counts the eight neighbours of cell 'idx' and produces its next state.
// Build option: GOL_TORUS_EN wraps rows and columns (toroidal board);
// without it, neighbours beyond the board edge count as dead.
module gol_cell_rule
    import gol_pkg::*;
(
    input  logic [CELLS-1:0] board,
    input  logic [IDX_W-1:0] idx,
    output logic [3:0]       nbr_count,
    output logic             next_cell
);

    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] rr;
    logic [COL_W-1:0] cc;
    logic             valid;

    assign row = idx[IDX_W-1:COL_W];
    assign col = idx[COL_W-1:0];

    // Sum the live neighbours; row/col arithmetic wraps naturally in its
    // width, and the edge mask is applied only for the bounded board
    always_comb begin
        nbr_count = '0;
        rr        = '0;
        cc        = '0;
        valid     = 1'b0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (dr != 0 || dc != 0) begin
                    rr = row + ROW_W'(dr);
                    cc = col + COL_W'(dc);
`ifdef GOL_TORUS_EN
                    valid = 1'b1;
`else
                    valid = !((dr < 0 && row == 3'd0)  ||
                              (dr > 0 && row == 3'd7)  ||
                              (dc < 0 && col == 4'd0)  ||
                              (dc > 0 && col == 4'd15));
`endif
                    if (valid) begin
                        nbr_count = nbr_count + 4'(board[{rr, cc}]);
                    end
                end
            end
        end
    end

    // Survival on 2 or 3 neighbours, birth on exactly 3
    always_comb begin
        if (board[idx]) begin
            next_cell = (nbr_count == 4'd2) || (nbr_count == 4'd3);
        end else begin
            next_cell = (nbr_count == 4'd3);
        end
    end

endmodule

// File: rtl/gol_board_engine.sv
// Game of Life board storage and generation engine.
// Holds the 128-cell board, writes cells from button edges in PROGRAM and,
// in RUN, computes one generation every STEP_DIV cycles by scanning one cell
// per cycle into a shadow register that is committed in a single cycle.
// Build option: GOL_TORUS_EN selects a toroidal board (see gol_cell_rule).
module gol_board_engine
    import gol_pkg::*;
#(
    parameter int STEP_DIV = 2_500_000,
    parameter int GEN_W    = 16
) (
    input  logic               clka,
    input  logic               rst_n,
    input  logic [1:0]         game_state,
    input  logic [IDX_W-1:0]   cell_idx,
    input  logic               btn0,
    input  logic               btn1,
    output logic [CELLS-1:0]   board,
    output logic               gen_busy,
    output logic               gen_done,
    output logic [GEN_W-1:0]   gen_count,
    output logic [7:0]         pop_count,
    output engine_dbg_t        dbg
);

    localparam int               DIV_W    = $clog2(STEP_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

    game_state_e       gs;
    engine_state_e     state;
    logic [DIV_W-1:0]  div_cnt;
    logic              div_wrap;
    logic              trigger;
    logic              btn0_q, btn0_h;
    logic              btn1_q, btn1_h;
    logic              edge0, edge1;
    logic [IDX_W-1:0]  idx;
    logic [7:0]        acc;
    logic [CELLS-1:0]  nxt;
    logic [3:0]        nbr_count;
    logic              next_cell;

    assign gs       = game_state_e'(game_state);
    assign div_wrap = (div_cnt == DIV_LAST);
    assign trigger  = (gs == RUN) && div_wrap;
    assign edge0    = btn0_q & ~btn0_h;
    assign edge1    = btn1_q & ~btn1_h;

    gol_cell_rule u_rule (
        .board     (board),
        .idx       (idx),
        .nbr_count (nbr_count),
        .next_cell (next_cell)
    );

    // Step divider: cleared in IDLE, counts and wraps in RUN, holds otherwise
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else begin
            case (gs)
                IDLE:    div_cnt <= '0;
                RUN:     div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
                default: div_cnt <= div_cnt;
            endcase
        end
    end

    // Button sample and history registers for rising-edge detection
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            btn0_q <= 1'b0;
            btn0_h <= 1'b0;
            btn1_q <= 1'b0;
            btn1_h <= 1'b0;
        end else begin
            btn0_q <= btn0;
            btn0_h <= btn0_q;
            btn1_q <= btn1;
            btn1_h <= btn1_q;
        end
    end

    // Engine FSM: programming writes, scan into nxt, single-cycle commit.
    // IDLE game state overrides everything and aborts a scan in progress.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state     <= E_IDLE;
            idx       <= '0;
            acc       <= '0;
            nxt       <= '0;
            board     <= '0;
            gen_busy  <= 1'b0;
            gen_done  <= 1'b0;
            gen_count <= '0;
            pop_count <= '0;
        end else begin
            gen_done <= 1'b0;
            if (gs == IDLE) begin
                state     <= E_IDLE;
                idx       <= '0;
                acc       <= '0;
                board     <= '0;
                gen_busy  <= 1'b0;
                gen_count <= '0;
                pop_count <= '0;
            end else begin
                case (state)
                    E_IDLE: begin
                        if (trigger) begin
                            state    <= E_SCAN;
                            idx      <= '0;
                            acc      <= '0;
                            gen_busy <= 1'b1;
                        end else if (gs == PROGRAM && (edge0 ^ edge1)) begin
                            board[cell_idx] <= edge1;
                        end
                    end
                    E_SCAN: begin
                        nxt[idx] <= next_cell;
                        acc      <= acc + 8'(next_cell);
                        idx      <= idx + IDX_W'(1);
                        if (idx == IDX_W'(CELLS - 1)) begin
                            state <= E_COMMIT;
                        end
                    end
                    E_COMMIT: begin
                        board     <= nxt;
                        pop_count <= acc;
                        gen_count <= gen_count + GEN_W'(1);
                        gen_done  <= 1'b1;
                        gen_busy  <= 1'b0;
                        state     <= E_IDLE;
                    end
                    default: begin
                        state    <= E_IDLE;
                        gen_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Debug view of the engine
    always_comb begin
        dbg.state     = state;
        dbg.idx       = idx;
        dbg.nbr_count = nbr_count;
    end

endmodule

// File: tb/tb_gol_board_engine.sv
// Directed self-checking bench for gol_board_engine with STEP_DIV = 130.
// Expected boards are hand-derived Life patterns (blinker, edge/wrap case).
module tb_gol_board_engine;
    import gol_pkg::*;

    localparam int STEP_DIV = 130;
    localparam int GEN_W    = 16;

    logic              clka = 1'b0;
    logic              rst_n;
    logic [1:0]        game_state;
    logic [6:0]        cell_idx;
    logic              btn0;
    logic              btn1;
    logic [127:0]      board;
    logic              gen_busy;
    logic              gen_done;
    logic [GEN_W-1:0]  gen_count;
    logic [7:0]        pop_count;
    engine_dbg_t       dbg;

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q[$];

    // Clock
    always #5 clka = ~clka;

    gol_board_engine #(
        .STEP_DIV (STEP_DIV),
        .GEN_W    (GEN_W)
    ) dut (
        .clka       (clka),
        .rst_n      (rst_n),
        .game_state (game_state),
        .cell_idx   (cell_idx),
        .btn0       (btn0),
        .btn1       (btn1),
        .board      (board),
        .gen_busy   (gen_busy),
        .gen_done   (gen_done),
        .gen_count  (gen_count),
        .pop_count  (pop_count),
        .dbg        (dbg)
    );

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] cells3(input int a, input int b, input int c);
        logic [127:0] v;
        v    = '0;
        v[a] = 1'b1;
        v[b] = 1'b1;
        v[c] = 1'b1;
        return v;
    endfunction

    // Single button pulse at one cell; leaves both buttons low
    task automatic press(input logic [6:0] idx, input logic set);
        cell_idx = idx;
        if (set) btn1 = 1'b1;
        else     btn0 = 1'b1;
        ticks(2);
        btn0 = 1'b0;
        btn1 = 1'b0;
        ticks(2);
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (gen_done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_busy(input int budget, output int n);
        n = 0;
        while (gen_busy !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int busy_n;
        int done_n;
        logic [127:0] exp_b;

        // Reset
        rst_n      = 1'b0;
        game_state = IDLE;
        cell_idx   = '0;
        btn0       = 1'b0;
        btn1       = 1'b0;
        ticks(3);
        check("rst_board", board, '0);
        check("rst_busy", gen_busy, 1'b0);
        check("rst_done", gen_done, 1'b0);
        check("rst_gen", gen_count, '0);
        check("rst_pop", pop_count, '0);
        check("rst_state", dbg.state, E_IDLE);
        rst_n = 1'b1;
        ticks(2);

        // Program a horizontal blinker
        game_state = PROGRAM;
        tick();
        press(7'd17, 1'b1);
        press(7'd18, 1'b1);
        press(7'd19, 1'b1);
        check("prog_board", board, cells3(17, 18, 19));
        check("prog_pop", pop_count, '0);
        check("prog_gen", gen_count, '0);

        // Both buttons rising together: no write
        cell_idx = 7'd5;
        btn0 = 1'b1;
        btn1 = 1'b1;
        ticks(3);
        check("both_edges", board, cells3(17, 18, 19));
        btn0 = 1'b0;
        btn1 = 1'b0;
        ticks(2);

        // btn1 held: one write only, so a clear during the hold sticks
        btn1 = 1'b1;
        ticks(3);
        check("hold_set", board[5], 1'b1);
        btn0 = 1'b1;
        ticks(3);
        check("hold_clr", board[5], 1'b0);
        btn0 = 1'b0;
        ticks(4);
        check("hold_one_write", board[5], 1'b0);
        btn1 = 1'b0;
        ticks(2);

        // Set then clear cell 5
        press(7'd5, 1'b1);
        check("set5", board[5], 1'b1);
        press(7'd5, 1'b0);
        check("clr5", board, cells3(17, 18, 19));

        // Blinker: two generations
        exp_q.push_back(cells3(2, 18, 34));
        exp_q.push_back(cells3(17, 18, 19));
        game_state = RUN;
        wait_done(400, n);
        check("gen1_seen", gen_done, 1'b1);
        exp_b = exp_q.pop_front();
        check("gen1_board", board, exp_b);
        check("gen1_pop", pop_count, 8'd3);
        check("gen1_count", gen_count, 16'd1);
        check("gen1_busy", gen_busy, 1'b0);
        n = 0;
        busy_n = 0;
        do begin
            tick();
            n++;
            if (gen_busy === 1'b1) busy_n++;
        end while (gen_done !== 1'b1 && n < 400);
        check("gen_spacing", n, 130);
        check("busy_cycles", busy_n, 129);
        exp_b = exp_q.pop_front();
        check("gen2_board", board, exp_b);
        check("gen2_count", gen_count, 16'd2);
        check("gen2_pop", pop_count, 8'd3);

        // PAUSE at scan cycle 60: scan completes, nothing new starts
        wait_busy(400, n);
        check("scan3_start", gen_busy, 1'b1);
        check("scan3_state", dbg.state, E_SCAN);
        check("scan3_idx0", dbg.idx, 7'd0);
        ticks(60);
        check("scan3_idx60", dbg.idx, 7'd60);
        game_state = PAUSE;
        wait_done(200, n);
        check("gen3_seen", gen_done, 1'b1);
        check("gen3_board", board, cells3(2, 18, 34));
        check("gen3_count", gen_count, 16'd3);
        done_n = 0;
        busy_n = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (gen_done === 1'b1) done_n++;
            if (gen_busy === 1'b1) busy_n++;
        end
        check("pause_no_done", done_n, 0);
        check("pause_no_busy", busy_n, 0);

        // Resume: divider was held at 60, so 70 cycles to the next scan
        game_state = RUN;
        wait_busy(400, n);
        check("resume_latency", n, 70);

        // Abort to IDLE at scan cycle 60
        ticks(60);
        game_state = IDLE;
        tick();
        check("abort_board", board, '0);
        check("abort_gen", gen_count, '0);
        check("abort_busy", gen_busy, 1'b0);
        check("abort_pop", pop_count, '0);
        check("abort_state", dbg.state, E_IDLE);
        done_n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (gen_done === 1'b1) done_n++;
        end
        check("abort_no_done", done_n, 0);

        // Edge / wrap case: cells 0, 1, 15 in row 0
        game_state = PROGRAM;
        tick();
        press(7'd0, 1'b1);
        press(7'd1, 1'b1);
        press(7'd15, 1'b1);
        check("wrap_prog", board, cells3(0, 1, 15));
        game_state = RUN;
        wait_done(400, n);
        check("wrap_seen", gen_done, 1'b1);
`ifdef GOL_TORUS_EN
        check("wrap_board", board, cells3(112, 0, 16));
        check("wrap_pop", pop_count, 8'd3);
`else
        check("wrap_board", board, '0);
        check("wrap_pop", pop_count, 8'd0);
`endif
        check("wrap_gen", gen_count, 16'd1);

        // Asynchronous reset mid-scan
        wait_busy(400, n);
        ticks(60);
        check("pre_rst_busy", gen_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_board", board, '0);
        check("arst_busy", gen_busy, 1'b0);
        check("arst_done", gen_done, 1'b0);
        check("arst_gen", gen_count, '0);
        check("arst_pop", pop_count, '0);
        ticks(2);
        rst_n = 1'b1;
        ticks(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gol_board_engine.md
# gol_board_engine

Cell-board storage and generation engine for the Game of Life datapath, directly downstream of the game-state FSM. It consumes `game_state[1:0]` and `cell_idx[6:0]` and holds the 8x16 (128-cell) board. In PROGRAM it writes cells from button presses. In RUN it computes one Life generation every `STEP_DIV` cycles by scanning one cell per cycle. It presents the board, the generation count and the population to the display stage.

## Interface
- `STEP_DIV`, 2_500_000: cycles between generation requests in RUN; must be ≥ 130.
- `GEN_W`, 16: width of `gen_count`.
- `clka  in  1`: single clock, rising edge.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `game_state  in  2`: 00 IDLE, 01 PROGRAM, 10 RUN, 11 PAUSE.
- `cell_idx  in  7`: cell addressed in PROGRAM; index = row*16 + col.
- `btn0  in  1`: level; a rising edge clears the addressed cell.
- `btn1  in  1`: level; a rising edge sets the addressed cell.
- `board  out  128`: current generation; bit i = cell i.
- `gen_busy  out  1`: high while in SCAN or COMMIT.
- `gen_done  out  1`: one-cycle pulse, first cycle a new generation is visible on `board`.
- `gen_count  out  GEN_W`: generations committed since IDLE; wraps from all-ones to 0.
- `pop_count  out  8`: live cells in the last committed generation, range 0..128.

## Operation
- Reset values: `board`=0, `gen_busy`=0, `gen_done`=0, `gen_count`=0, `pop_count`=0. Engine state is IDLE, divider is 0, button history regs are 0.
- Button edges: `btn0`/`btn1` are registered once. An edge is current high while the previous sample was low.
- IDLE (00): every cycle, clear `board`, `gen_count`, `pop_count` and the divider. Abort any scan, so the engine returns to E_IDLE and `gen_busy` is 0 next cycle.
- PROGRAM (01), engine in E_IDLE only:
  - `btn1` edge alone: `board[cell_idx]` <= 1.
  - `btn0` edge alone: `board[cell_idx]` <= 0.
  - Both edges in the same cycle: no write.
  - Edges while `gen_busy` are dropped.
- RUN (10): the divider counts 0..STEP_DIV-1 and wraps. The wrap cycle is a trigger. A trigger with the engine in E_IDLE starts a scan. A trigger while busy is dropped.
- PAUSE (11): the divider holds its value and no new scan starts. A scan already in progress runs to completion.
- Engine FSM:
  - E_IDLE -> E_SCAN on an accepted trigger; `idx` <= 0, population accumulator <= 0.
  - E_SCAN: each cycle, apply the rule to cell `idx` of `board`:
    - Alive with 2 or 3 live neighbours: alive.
    - Dead with exactly 3 live neighbours: born.
    - Otherwise: dead.
    - Write the result to `nxt[idx]`, add it to the accumulator, and increment `idx`.
    - After `idx`=127, go to E_COMMIT.
  - E_COMMIT: `board` <= `nxt`, `pop_count` <= accumulator, `gen_count` += 1, `gen_done` <= 1; go to E_IDLE.
- `board` is never modified during E_SCAN, so every cell is evaluated against one consistent generation.
- Neighbour count is 0..8, 4 bits. Accumulator is 8 bits; 128 fits without overflow.

## Timing
- Trigger accepted in cycle T: `gen_busy`=1 from T+1 through T+129.
  - SCAN runs T+1..T+128 (idx 0..127).
  - COMMIT is T+129.
  - New `board`, `pop_count`, `gen_count` and `gen_done`=1 are visible in T+130, where `gen_busy`=0.
- Generation period in RUN is exactly STEP_DIV cycles, not counting time in PAUSE.
- PROGRAM write: button edge registered at edge k makes the write visible on `board` after edge k+1 (2-cycle latency from the pin).
- A `game_state` change to IDLE mid-scan is a synchronous abort. `board` clears the next cycle and no `gen_done` is issued.
- A `rst_n` assertion anywhere forces the reset values immediately, asynchronously.

## Configuration
- `GOL_TORUS_EN` defined: the board is toroidal.
  - Column -1 maps to 15 and column 16 to 0.
  - Row -1 maps to 7 and row 8 to 0.
- `GOL_TORUS_EN` undefined: neighbours outside the 8x16 board count as dead.

## Structure
- Package `gol_pkg` holds:
  - game-state encodings IDLE/PROGRAM/RUN/PAUSE;
  - `ROWS`=8, `COLS`=16, `CELLS`=128;
  - the engine state enum E_IDLE/E_SCAN/E_COMMIT.
- Sub-module `gol_cell_rule` (combinational): takes the 128-bit board and a 7-bit index. It outputs the 4-bit neighbour count and the next-state bit, and contains the `GOL_TORUS_EN` wrap logic.
- Top holds the divider, button edge regs, engine FSM, the `nxt` register, the accumulator and the output registers.

## Test plan
- Reset then PROGRAM: pulse `btn1` at `cell_idx` 17, 18, 19 -> `board` = bits 17,18,19 only, `pop_count`=0, `gen_count`=0.
- Blinker: the above board, RUN with STEP_DIV=130 -> after the first `gen_done`, `board` = bits 2,18,34, `pop_count`=3, `gen_count`=1. Second `gen_done` restores bits 17,18,19 with `gen_count`=2. Spacing between `gen_done` pulses is 130 cycles.
- Wrap: program cells 0, 1, 15 and RUN one generation:
  - with `GOL_TORUS_EN`: `board` = bits 112, 0, 16, `pop_count`=3;
  - without it: `board`=0, `pop_count`=0.
- Button corners in PROGRAM:
  - `btn0`+`btn1` rising together at idx 5 -> no change;
  - `btn1` held high for 10 cycles -> exactly one write;
  - `btn0` edge at idx 5 after a set -> bit 5 cleared.
- PAUSE mid-scan: switch to 11 at scan cycle 60 -> scan completes, `gen_done` pulses once, and no further scan starts until RUN resumes. The divider resumes from its held value.
- Abort: switch to IDLE at scan cycle 60 -> `board`=0, `gen_count`=0, `gen_busy`=0 the next cycle, no `gen_done`. An async `rst_n` low mid-scan -> all outputs 0 immediately.
